// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bundles the instruction-memory bus and the decode
// handshake of the fetch stage.
//   imem_addr / imem_read_en -> memory wrapper, imem_data <- wrapper (same cycle)
//   out_valid / out_instr / out_pc -> decode, out_ready <- decode
// master = fetch stage, slave = memory wrapper + decode side.
interface instruction_fetch_if #(
  parameter int AW        = 8,
  parameter int MEM_WIDTH = 32
);
  logic [AW-1:0]        imem_addr;
  logic                 imem_read_en;
  logic [MEM_WIDTH-1:0] imem_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [MEM_WIDTH-1:0] out_instr;
  logic [AW-1:0]        out_pc;

  modport master (
    output imem_addr, imem_read_en, out_valid, out_instr, out_pc,
    input  imem_data, out_ready
  );

  modport slave (
    input  imem_addr, imem_read_en, out_valid, out_instr, out_pc,
    output imem_data, out_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register driving a same-cycle instruction memory,
// feeding an in-order FIFO of {pc, instr} toward decode.
//   i_clk         clock, rising edge
//   i_reset_n     synchronous active-low reset
//   i_fetch_en    1 = fetch allowed; 0 = PC frozen, FIFO still drains
//   i_redirect    branch/jump taken: flush FIFO, load i_redirect_pc
//   i_redirect_pc redirect target word address
//   bus           instruction_fetch_if.master (imem bus + decode handshake)
module instruction_fetch #(
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_SIZE   = 256,
  parameter int FIFO_DEPTH = 2,
  parameter int RESET_PC   = 0,
  localparam int AW        = $clog2(MEM_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_fetch_en,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  instruction_fetch_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0]        pc;
    logic [MEM_WIDTH-1:0] instr;
  } entry_t;

  entry_t        r_buf [FIFO_DEPTH];
  logic [AW-1:0] r_pc;
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;

  logic          w_valid, w_full, w_pop, w_push;
  logic [AW-1:0] w_pc_nxt;
  entry_t        w_head;

  assign w_valid = (r_cnt != '0);
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  // Redirect kills both sides: the head seen this cycle is discarded, not consumed.
  assign w_pop   = w_valid & bus.out_ready & ~i_redirect;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_fetch_en & ~i_redirect & (~w_full | w_pop);
  // Explicit wrap so non-power-of-two memory depths also roll over to 0.
  assign w_pc_nxt = (r_pc == AW'(MEM_SIZE - 1)) ? '0 : r_pc + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pc  <= AW'(RESET_PC);
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_redirect) begin
      r_pc  <= i_redirect_pc;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_pc <= w_pc_nxt;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && w_push) r_buf[r_wr] <= '{pc: r_pc, instr: bus.imem_data};
  end

  assign w_head           = r_buf[r_rd];
  assign bus.imem_addr    = r_pc;
  assign bus.imem_read_en = w_push;
  assign bus.out_valid    = w_valid;
  assign bus.out_instr    = w_valid ? w_head.instr : '0;
  assign bus.out_pc       = w_valid ? w_head.pc    : '0;
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  logic       clk;
  logic       rst_n, fetch_en, redirect;
  logic [7:0] redirect_pc;
  logic       b_rst_n, b_fetch_en;
  int         n_vec, n_err;

  instruction_fetch_if #(.AW(8), .MEM_WIDTH(32)) if_a ();
  instruction_fetch_if #(.AW(8), .MEM_WIDTH(32)) if_b ();

  // Memory model: word k holds 0x1000 + k.
  assign if_a.imem_data = 32'h1000 + 32'(if_a.imem_addr);
  assign if_b.imem_data = 32'h1000 + 32'(if_b.imem_addr);

  instruction_fetch #(.MEM_WIDTH(32), .MEM_SIZE(256), .FIFO_DEPTH(2), .RESET_PC(0)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_fetch_en(fetch_en), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .bus(if_a)
  );

  instruction_fetch #(.MEM_WIDTH(32), .MEM_SIZE(256), .FIFO_DEPTH(2), .RESET_PC(254)) u_dut_w (
    .i_clk(clk), .i_reset_n(b_rst_n), .i_fetch_en(b_fetch_en), .i_redirect(1'b0),
    .i_redirect_pc(8'h00), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 0; fetch_en = 0; redirect = 0; redirect_pc = 8'h00;
    if_a.out_ready = 0;
    b_rst_n = 0; b_fetch_en = 0; if_b.out_ready = 0;

    // Reset state
    step(); step();
    chk("rst_valid", 32'(if_a.out_valid), 0);
    chk("rst_instr", if_a.out_instr, 0);
    chk("rst_pc",    32'(if_a.out_pc), 0);
    chk("rst_addr",  32'(if_a.imem_addr), 0);

    // Stream: one instruction per cycle, visible one cycle after push
    rst_n = 1; fetch_en = 1; if_a.out_ready = 1; #1;
    chk("s_rden0",  32'(if_a.imem_read_en), 1);
    chk("s_valid0", 32'(if_a.out_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("s_valid%0d", k), 32'(if_a.out_valid), 1);
      chk($sformatf("s_pc%0d", k),    32'(if_a.out_pc), 32'(k));
      chk($sformatf("s_instr%0d", k), if_a.out_instr, 32'h1000 + 32'(k));
    end

    // Backpressure fill
    rst_n = 0; if_a.out_ready = 0;
    step();
    rst_n = 1; #1;
    chk("bp_rden0", 32'(if_a.imem_read_en), 1);
    step();
    chk("bp_rden1", 32'(if_a.imem_read_en), 1);
    chk("bp_pc1",   32'(if_a.out_pc), 0);
    step();
    chk("bp_rden_full", 32'(if_a.imem_read_en), 0);
    chk("bp_addr_hold", 32'(if_a.imem_addr), 2);
    chk("bp_valid",     32'(if_a.out_valid), 1);
    chk("bp_head",      32'(if_a.out_pc), 0);
    chk("bp_instr",     if_a.out_instr, 32'h1000);
    step();
    chk("bp_head_stable", 32'(if_a.out_pc), 0);
    chk("bp_addr_stable", 32'(if_a.imem_addr), 2);
    chk("bp_valid_stable", 32'(if_a.out_valid), 1);
    if_a.out_ready = 1; #1;
    chk("bp_pushpop_rden", 32'(if_a.imem_read_en), 1);
    step();
    if_a.out_ready = 0; #1;
    chk("bp_after_head", 32'(if_a.out_pc), 1);
    chk("bp_after_addr", 32'(if_a.imem_addr), 3);
    chk("bp_after_full", 32'(if_a.imem_read_en), 0);
    chk("bp_after_valid", 32'(if_a.out_valid), 1);

    // Redirect flush with FIFO holding pcs 5 and 6
    if_a.out_ready = 1;
    repeat (4) step();
    chk("rd_pre_head",  32'(if_a.out_pc), 5);
    chk("rd_pre_addr",  32'(if_a.imem_addr), 7);
    chk("rd_pre_instr", if_a.out_instr, 32'h1005);
    redirect = 1; redirect_pc = 8'h40; #1;
    chk("rd_nopush", 32'(if_a.imem_read_en), 0);
    step();
    redirect = 0; #1;
    chk("rd_n1_valid", 32'(if_a.out_valid), 0);
    chk("rd_n1_addr",  32'(if_a.imem_addr), 32'h40);
    chk("rd_n1_rden",  32'(if_a.imem_read_en), 1);
    step();
    chk("rd_n2_valid", 32'(if_a.out_valid), 1);
    chk("rd_n2_pc",    32'(if_a.out_pc), 32'h40);
    chk("rd_n2_instr", if_a.out_instr, 32'h1040);

    // fetch_en gating: two entries drain, pc frozen
    if_a.out_ready = 0;
    step();
    fetch_en = 0; if_a.out_ready = 1; #1;
    chk("fe_rden",  32'(if_a.imem_read_en), 0);
    chk("fe_head0", 32'(if_a.out_pc), 32'h40);
    step();
    chk("fe_head1",  32'(if_a.out_pc), 32'h41);
    chk("fe_valid1", 32'(if_a.out_valid), 1);
    step();
    chk("fe_empty", 32'(if_a.out_valid), 0);
    chk("fe_rden2", 32'(if_a.imem_read_en), 0);
    chk("fe_addr",  32'(if_a.imem_addr), 32'h42);
    chk("fe_instr", if_a.out_instr, 0);

    // Back-to-back redirects: last wins, no push in either cycle
    fetch_en = 1; redirect = 1; redirect_pc = 8'h10; #1;
    chk("bb_nopush0", 32'(if_a.imem_read_en), 0);
    step();
    redirect_pc = 8'h20; #1;
    chk("bb_nopush1", 32'(if_a.imem_read_en), 0);
    chk("bb_valid",   32'(if_a.out_valid), 0);
    step();
    redirect = 0; #1;
    chk("bb_addr", 32'(if_a.imem_addr), 32'h20);
    step();
    chk("bb_pc", 32'(if_a.out_pc), 32'h20);

    // Reset mid-stream at pc=17
    rst_n = 0;
    step();
    rst_n = 1;
    repeat (17) step();
    chk("mr_addr",  32'(if_a.imem_addr), 17);
    chk("mr_valid", 32'(if_a.out_valid), 1);
    chk("mr_pc",    32'(if_a.out_pc), 16);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mr_rvalid", 32'(if_a.out_valid), 0);
    chk("mr_raddr",  32'(if_a.imem_addr), 0);
    chk("mr_rinstr", if_a.out_instr, 0);
    chk("mr_rpc",    32'(if_a.out_pc), 0);

    // PC wrap on the RESET_PC=254 instance
    b_rst_n = 0;
    step();
    b_rst_n = 1; b_fetch_en = 1; if_b.out_ready = 1; #1;
    chk("wr_addr0", 32'(if_b.imem_addr), 254);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e_pc, e_addr;
      e_pc   = 8'(254 + k);
      e_addr = 8'(255 + k);
      step();
      chk($sformatf("wr_pc%0d", k),   32'(if_b.out_pc), 32'(e_pc));
      chk($sformatf("wr_addr%0d", k + 1), 32'(if_b.imem_addr), 32'(e_addr));
      chk($sformatf("wr_instr%0d", k), if_b.out_instr, 32'h1000 + 32'(e_pc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage sitting directly upstream of the instruction memory wrapper. Holds the program counter and drives the word address into the memory wrapper, whose read data returns combinationally in the same cycle. Each fetched word is captured, together with its PC, into a small in-order FIFO. The FIFO presents instructions to decode over a valid/ready handshake. Supports stalls via backpressure, a global fetch enable, and a branch/jump redirect that flushes the FIFO.

Parameters:
MEM_WIDTH, 32, instruction word width in bits
MEM_SIZE, 256, instruction memory depth in words; PC width AW = $clog2(MEM_SIZE)
FIFO_DEPTH, 2, fetch buffer entries; power of two, >= 2
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  synchronous active-low reset
fetch_en  in  1  1 = fetching allowed; 0 = PC holds, nothing pushed
redirect  in  1  branch/jump taken; flush and reload PC
redirect_pc  in  AW  target word address, sampled when redirect=1
imem_addr  out  AW  word address to instruction memory wrapper (= pc, combinational)
imem_read_en  out  1  high in cycles where a fetch is accepted (push)
imem_data  in  MEM_WIDTH  read data from the wrapper, valid in the same cycle
out_valid  out  1  FIFO head holds a valid instruction
out_ready  in  1  decode accepts the head this cycle
out_instr  out  MEM_WIDTH  head instruction word
out_pc  out  AW  PC of the head instruction

Behaviour:
- Reset (reset_n=0 at edge): pc<=RESET_PC; FIFO count, read pointer and write pointer <= 0. Results: out_valid=0, out_instr=0, out_pc=0 (masked to 0 when empty). Reset overrides redirect and every other input.
- Pop: pop = out_valid & out_ready & ~redirect.
- Push: push = fetch_en & ~redirect & (count<FIFO_DEPTH | pop). imem_read_en = push.
- A push writes {pc, imem_data} at the write pointer and sets pc <= pc+1, wrapping modulo MEM_SIZE (MEM_SIZE-1 -> 0). With no push, pc holds.
- Fetch-to-output latency: an instruction pushed in cycle N is visible on out_* in cycle N+1. No combinational path from imem_data to out_instr.
- Outputs come from storage: out_valid = (count != 0). out_instr and out_pc come from the head entry.
- Simultaneous push and pop while full: both occur and count is unchanged. Simultaneous push and pop while empty cannot occur, because pop requires out_valid.
- count update: count' = count + push - pop, in the range 0..FIFO_DEPTH.
- Pointers: width $clog2(FIFO_DEPTH) and wrap naturally.
- Redirect (priority over fetch and pop):
  - Cycle N, redirect=1: FIFO flushed (count, read pointer and write pointer <= 0), pc <= redirect_pc, no push, no pop. A head presented with out_ready=1 in that cycle is discarded, not consumed.
  - Cycle N+1: out_valid=0, imem_addr=redirect_pc, and a push occurs if fetch_en=1.
  - Cycle N+2: out_valid=1 with out_pc=redirect_pc.
- Back-to-back redirects: the last one wins, and each cycle with redirect=1 produces no push.
- fetch_en=0: the FIFO keeps draining normally and pc is frozen.
- Stall: when out_ready=0 and the FIFO is full, pc holds and out_* hold stable with out_valid=1 until accepted. Once out_valid is asserted, it never drops without a pop, redirect or reset.
- Reset mid-operation: all buffered instructions are lost and the next fetch address is RESET_PC.

Test Plan:
- Reset then stream: reset_n=0 for 2 cycles, then fetch_en=1, out_ready=1, memory word k = 0x1000+k. Required: out_valid first high one cycle after the first push; out_pc=0,1,2,... and out_instr=0x1000,0x1001,... with one instruction accepted per cycle.
- Backpressure fill: out_ready=0 from reset with fetch_en=1. Required: exactly 2 pushes (pc 0,1); pc then holds at 2 and imem_read_en=0. out_valid=1 with out_pc=0 holds stable. Raising out_ready for 1 cycle pops pc 0 and pushes pc 2 in the same cycle; count stays 2.
- Redirect flush: FIFO holds pcs 5 and 6; assert redirect with redirect_pc=0x40 while out_ready=1. Required: next cycle out_valid=0 and imem_addr=0x40; the cycle after, out_pc=0x40. Pcs 5 and 6 never appear on the output as accepted.
- PC wrap: RESET_PC=254, MEM_SIZE=256, stream with out_ready=1. Required: output PCs 254, 255, 0, 1 in that order.
- fetch_en gating: with the FIFO holding 2 entries, deassert fetch_en and hold out_ready=1. Required: the 2 entries drain in 2 cycles, then out_valid=0, imem_read_en=0 and pc is unchanged.
- Reset mid-stream: reset_n=0 for one cycle while out_valid=1 and pc=17. Required: the next cycle out_valid=0, pc=RESET_PC and out_instr=0.
